// File: rtl/gen_sched.sv
// gen_sched: round-robin scheduler over four result generators.
// Each selected generator gets a one-cycle enable pulse. Its result is then
// captured and held on out_data for HOLD_CYCLES cycles before the scheduler
// moves on to the next generator in gen_mask.
// Optional feature: define GEN_SCHED_TIMEOUT_EN to bound the wait for a
// result to TIMEOUT cycles. On expiry the sticky err flag is set.
//
// state  | meaning
// IDLE   | not scheduling, waiting for start with a non-empty gen_mask
// ENABLE | one-cycle enable pulse to generator cur
// WAIT   | waiting for gen_valid[cur] (bounded when the timeout is enabled)
// HOLD   | result on out_data, dwelling HOLD_CYCLES cycles
module gen_sched #(
    parameter int HOLD_CYCLES = 10,
    parameter int TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic [3:0]  gen_mask,
    input  logic [3:0]  gen_valid,
    input  logic [63:0] gen_data,
    output logic [3:0]  gen_en,
    output logic [15:0] out_data,
    output logic        out_valid,
    output logic [1:0]  out_sel,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, ENABLE, WAIT, HOLD} state_t;

    // A zero dwell would skip HOLD entirely, so it is promoted to one cycle.
    localparam int HOLD_EFF = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
    localparam int HW       = (HOLD_EFF > 1) ? $clog2(HOLD_EFF) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_EFF - 1);

    state_t        state, state_nx;
    logic [1:0]    cur, cur_nx;
    logic [HW-1:0] hold_cnt, hold_nx;
    logic [15:0]   data_nx;
    logic          valid_nx;
    logic [1:0]    adv_cur;
    state_t        adv_state;

`ifdef GEN_SCHED_TIMEOUT_EN
    localparam int TO_EFF = (TIMEOUT < 1) ? 1 : TIMEOUT;
    localparam int TW     = (TO_EFF > 1) ? $clog2(TO_EFF) : 1;
    localparam logic [TW-1:0] TO_LOAD = TW'(TO_EFF - 1);

    logic [TW-1:0] to_cnt, to_nx;
    logic          err_q, err_nx;
`endif

    function automatic logic [1:0] lowest_bit(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    // Nearest set bit above c, wrapping; c itself when no other bit is set.
    function automatic logic [1:0] next_bit(input logic [3:0] m, input logic [1:0] c);
        logic [1:0] idx;
        logic [1:0] res;
        res = c;
        for (int k = 3; k >= 1; k--) begin
            idx = c + 2'(k);
            if (m[idx]) res = idx;
        end
        return res;
    endfunction

    // Next-state and next-register values; stop overrides everything else.
    always_comb begin
        state_nx  = state;
        cur_nx    = cur;
        hold_nx   = hold_cnt;
        data_nx   = out_data;
        valid_nx  = 1'b0;
        adv_cur   = next_bit(gen_mask, cur);
        adv_state = (gen_mask == 4'b0000) ? IDLE : ENABLE;
`ifdef GEN_SCHED_TIMEOUT_EN
        to_nx     = to_cnt;
        err_nx    = err_q;
`endif
        case (state)
            IDLE: begin
                if (start && (gen_mask != 4'b0000)) begin
                    state_nx = ENABLE;
                    cur_nx   = lowest_bit(gen_mask);
                end
            end
            ENABLE: begin
                state_nx = WAIT;
`ifdef GEN_SCHED_TIMEOUT_EN
                to_nx    = TO_LOAD;
`endif
            end
            WAIT: begin
                if (gen_valid[cur]) begin
                    data_nx  = gen_data[{cur, 4'b0000} +: 16];
                    valid_nx = 1'b1;
                    hold_nx  = HOLD_LOAD;
                    state_nx = HOLD;
                end
`ifdef GEN_SCHED_TIMEOUT_EN
                else if (to_cnt == '0) begin
                    err_nx   = 1'b1;
                    cur_nx   = adv_cur;
                    state_nx = adv_state;
                end else begin
                    to_nx = to_cnt - TW'(1);
                end
`endif
            end
            HOLD: begin
                if (hold_cnt == '0) begin
                    cur_nx   = adv_cur;
                    state_nx = adv_state;
                end else begin
                    hold_nx = hold_cnt - HW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
        if (stop) begin
            state_nx = IDLE;
            cur_nx   = cur;
            data_nx  = out_data;
            valid_nx = 1'b0;
`ifdef GEN_SCHED_TIMEOUT_EN
            err_nx   = err_q;
`endif
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cur       <= 2'd0;
            hold_cnt  <= '0;
            out_data  <= 16'h0000;
            out_valid <= 1'b0;
`ifdef GEN_SCHED_TIMEOUT_EN
            to_cnt    <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state     <= state_nx;
            cur       <= cur_nx;
            hold_cnt  <= hold_nx;
            out_data  <= data_nx;
            out_valid <= valid_nx;
`ifdef GEN_SCHED_TIMEOUT_EN
            to_cnt    <= to_nx;
            err_q     <= err_nx;
`endif
        end
    end

    assign gen_en  = (state == ENABLE) ? (4'b0001 << cur) : 4'b0000;
    assign out_sel = cur;
    assign busy    = (state != IDLE);

`ifdef GEN_SCHED_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gen_sched.sv
// tb_gen_sched: directed bench for gen_sched with a generator response model
// and a scoreboard of expected captured results.
module tb_gen_sched;

    localparam int HOLD = 3;
    localparam int TO   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [3:0]  gen_mask = 4'b0000;
    logic [3:0]  gen_valid = 4'b0000;
    logic [63:0] gen_data = 64'h0;
    logic [3:0]  gen_en;
    logic [15:0] out_data;
    logic        out_valid;
    logic [1:0]  out_sel;
    logic        busy;
    logic        err;

    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    int          cap_cnt = 0;
    int          last_v = -1;
    logic        chk_spacing = 1'b0;

    logic [3:0]  resp_mask = 4'b0000;
    logic [15:0] resp_base = 16'h0010;
    logic [3:0]  extra_valid = 4'b0000;
    logic [15:0] extra_data = 16'h0000;
    int          dly[4] = '{default: 0};
    logic [15:0] exp_q[$];
    int          en_log[$];
    int          en_t[$];

    gen_sched #(.HOLD_CYCLES(HOLD), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .gen_mask(gen_mask), .gen_valid(gen_valid), .gen_data(gen_data),
        .gen_en(gen_en), .out_data(out_data), .out_valid(out_valid),
        .out_sel(out_sel), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_resp();
        dly = '{default: 0};
        resp_mask = 4'b0000;
        exp_q.delete();
    endtask

    task automatic wait_en(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (en_log.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk({tag, "_en_reached"}, 32'(en_log.size() >= n), 1);
    endtask

    // Monitor + generator model, evaluated 1 time unit after each rising edge.
    always @(posedge clk) begin
        logic [3:0] resp_v;
        #1;
        cyc++;
        if (out_valid === 1'b1) begin
            cap_cnt++;
            if (exp_q.size() == 0) chk("unexpected_out_valid", 1, 0);
            else chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
            if (chk_spacing && last_v >= 0) chk("valid_spacing", cyc - last_v, HOLD + 3);
            last_v = cyc;
        end
        resp_v = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (dly[i] > 0) begin
                dly[i]--;
                if (dly[i] == 0) begin
                    resp_v[i] = 1'b1;
                    exp_q.push_back(resp_base + 16'(i));
                end
            end
        end
        if (gen_en !== 4'b0000) begin
            chk("gen_en_onehot", 32'($onehot(gen_en)), 1);
            for (int i = 0; i < 4; i++) begin
                if (gen_en[i] === 1'b1) begin
                    en_log.push_back(i);
                    en_t.push_back(cyc);
                    if (resp_mask[i]) dly[i] = 2;
                end
            end
        end
        gen_valid = resp_v | extra_valid;
        for (int i = 0; i < 4; i++)
            gen_data[16*i +: 16] = resp_v[i] ? (resp_base + 16'(i)) : extra_data;
    end

    initial begin
        int exp_a[5] = '{0, 1, 2, 3, 0};
        int bad;
        int c0;
        int k;

        // Reset state
        tick(); tick();
        chk("rst_gen_en", 32'(gen_en), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_out_sel", 32'(out_sel), 0);
        rst = 1'b1;
        tick();

        // Full rotation over all four generators
        en_log.delete(); cap_cnt = 0; last_v = -1; chk_spacing = 1'b1;
        resp_base = 16'h0010; resp_mask = 4'b1111; gen_mask = 4'b1111;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_en(5, 80, "rot");
        for (int i = 0; i < 5; i++) chk("rot_order", 32'(en_log[i]), 32'(exp_a[i]));
        chk("rot_captures", cap_cnt, 4);
        tick();
        chk("rot_busy_wait", 32'(busy), 1);
        stop = 1'b1;
        clear_resp();
        tick();
        stop = 1'b0;
        chk("stop_busy", 32'(busy), 0);
        chk("stop_gen_en", 32'(gen_en), 0);
        chk("stop_out_data", 32'(out_data), 32'h0013);

        // start together with stop while idle
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("startstop_busy", 32'(busy), 0);
        tick();
        chk("startstop_gen_en", 32'(gen_en), 0);

        // Single generator keeps being re-selected
        en_log.delete(); cap_cnt = 0; last_v = -1; bad = 0;
        resp_base = 16'h0100; resp_mask = 4'b1111; gen_mask = 4'b0100;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (en_log.size() < 3 && k < 60) begin
            if (busy && out_sel !== 2'd2) bad++;
            tick();
            k++;
        end
        chk("single_en_reached", 32'(en_log.size() >= 3), 1);
        for (int i = 0; i < 3; i++) chk("single_order", 32'(en_log[i]), 2);
        chk("single_out_sel_bad", bad, 0);
        chk("single_captures", cap_cnt, 2);
        stop = 1'b1;
        clear_resp();
        tick();
        stop = 1'b0;
        chk_spacing = 1'b0;

        // Valid on a non-selected index is ignored
        en_log.delete(); c0 = cap_cnt;
        gen_mask = 4'b0001;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_en(1, 10, "foreign");
        extra_valid = 4'b0010; extra_data = 16'hBEEF;
        tick(); tick(); tick();
        chk("foreign_no_capture", cap_cnt, c0);
        chk("foreign_out_data", 32'(out_data), 32'h0102);
        chk("foreign_busy", 32'(busy), 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        extra_valid = 4'b0000; extra_data = 16'h0000;

        // Empty mask start is ignored
        gen_mask = 4'b0000; en_log.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("empty_busy", 32'(busy), 0);
        tick();
        chk("empty_no_en", en_log.size(), 0);

        // Silent generator 0
        en_log.delete(); en_t.delete(); c0 = cap_cnt;
        resp_base = 16'h0300; resp_mask = 4'b0010; gen_mask = 4'b0011;
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef GEN_SCHED_TIMEOUT_EN
        wait_en(2, 40, "to");
        chk("to_first", 32'(en_log[0]), 0);
        chk("to_second", 32'(en_log[1]), 1);
        chk("to_latency", en_t[1] - en_t[0], TO + 1);
        chk("to_err", 32'(err), 1);
        chk("to_no_capture", cap_cnt, c0);
        k = 0;
        while (cap_cnt == c0 && k < 20) begin tick(); k++; end
        chk("to_gen1_capture", cap_cnt, c0 + 1);
        stop = 1'b1;
        clear_resp();
        tick();
        stop = 1'b0;
        chk("to_err_sticky", 32'(err), 1);
`else
        for (int i = 0; i < 20; i++) tick();
        chk("wait_en_count", en_log.size(), 1);
        chk("wait_busy", 32'(busy), 1);
        chk("wait_err", 32'(err), 0);
        chk("wait_no_capture", cap_cnt, c0);
        stop = 1'b1;
        clear_resp();
        tick();
        stop = 1'b0;
`endif

        // Reset during HOLD
        en_log.delete(); c0 = cap_cnt;
        resp_base = 16'h0200; resp_mask = 4'b1111; gen_mask = 4'b1111;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (cap_cnt == c0 && k < 20) begin tick(); k++; end
        chk("hold_reached", cap_cnt, c0 + 1);
        tick();
        rst = 1'b0;
        #1;
        chk("arst_gen_en", 32'(gen_en), 0);
        chk("arst_out_data", 32'(out_data), 0);
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_err", 32'(err), 0);
        chk("arst_out_sel", 32'(out_sel), 0);
        clear_resp();
        tick();
        rst = 1'b1;
        en_log.delete(); c0 = cap_cnt;
        resp_mask = 4'b1111;
        for (int i = 0; i < 10; i++) tick();
        chk("post_rst_no_en", en_log.size(), 0);
        chk("post_rst_no_valid", cap_cnt, c0);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_en(1, 10, "restart");
        chk("restart_first", 32'(en_log[0]), 0);
        stop = 1'b1;
        clear_resp();
        tick();
        stop = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gen_sched.md
GEN_SCHED -- requirements
Module: gen_sched

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 10: dwell cycles per displayed result (1 s at 10 Hz).
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum WAIT cycles, used only when GEN_SCHED_TIMEOUT_EN is defined.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: start request, sampled each edge.
REQ-006 SHALL have port stop, input, 1 bit: abort request, sampled each edge.
REQ-007 SHALL have port gen_mask, input, 4 bits: generators participating in the rotation.
REQ-008 SHALL have port gen_valid, input, 4 bits: per-generator valid flags.
REQ-009 SHALL have port gen_data, input, 64 bits: four 16-bit results; generator i drives bits [16i+15:16i].
REQ-010 SHALL have port gen_en, output, 4 bits: one-hot, single-cycle enable to the selected generator.
REQ-011 SHALL have port out_data, output, 16 bits: last captured result.
REQ-012 SHALL have port out_valid, output, 1 bit: one-cycle pulse when out_data updates.
REQ-013 SHALL have port out_sel, output, 2 bits: index of the current generator.
REQ-014 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-015 SHALL have port err, output, 1 bit: sticky timeout flag.

Function
REQ-016 SHALL implement the FSM states IDLE, ENABLE, WAIT and HOLD.
REQ-017 SHALL move IDLE->ENABLE on start=1 with gen_mask!=0, loading cur with the lowest set gen_mask bit; start with gen_mask==0 is ignored.
REQ-018 SHALL drive gen_en = one-hot(cur) for exactly the one cycle spent in ENABLE, then go to WAIT; gen_en is 0 in all other states.
REQ-019 SHALL, in WAIT, capture gen_data[cur] into out_data on the first edge where gen_valid[cur]=1 and go to HOLD; gen_valid on other indices is ignored.
REQ-020 SHALL assert out_valid during the first HOLD cycle only, so capture-to-out_valid latency is 1 cycle.
REQ-021 SHALL keep HOLD for exactly HOLD_CYCLES cycles, where HOLD_CYCLES=0 is treated as 1, then advance cur and go to ENABLE.
REQ-022 SHALL advance cur to the next set gen_mask bit above cur, wrapping 3->0; if cur is the only set bit it stays; if gen_mask==0 at advance time the FSM goes to IDLE.
REQ-023 SHALL sample gen_mask only at start and at advance; changes mid-cycle do not affect cur.
REQ-024 SHALL return to IDLE on the next edge when stop=1 in any state; stop beats start in the same cycle; out_data and err are retained.
REQ-025 SHALL ignore start while busy=1.
REQ-026 SHALL hold out_data across IDLE and never truncate it (16-bit pass-through).
REQ-027 SHALL drive out_sel = cur continuously.

Reset
REQ-028 SHALL, on rst=0 and asynchronously, set state=IDLE, cur=0, gen_en=0, out_data=0, out_valid=0, err=0, busy=0, and clear all counters.
REQ-029 SHALL abort any operation when reset is asserted mid-operation; no gen_en pulse or out_valid pulse appears after rst is released without a new start.

Configuration
REQ-030 SHALL, with GEN_SCHED_TIMEOUT_EN defined, leave WAIT after TIMEOUT cycles without gen_valid[cur], set err=1 (cleared only by reset), leave out_data unchanged with no out_valid pulse, and advance as in REQ-022 directly to ENABLE.
REQ-031 SHALL, with GEN_SCHED_TIMEOUT_EN undefined, wait in WAIT indefinitely, tie err to 0, and omit the timeout counter.

Verification
REQ-032 SHALL cover: gen_mask=4'b1111, start, each generator returns 16'h0010+i two cycles after its gen_en -> gen_en order 0,1,2,3,0; out_data 0010,0011,0012,0013; out_valid pulses spaced by HOLD_CYCLES+3 cycles.
REQ-033 SHALL cover: gen_mask=4'b0100, start -> gen_en=4'b0100 every iteration, out_sel=2 throughout.
REQ-034 SHALL cover: stop asserted in WAIT -> IDLE next cycle, busy=0, gen_en=0, out_data retained; start together with stop in IDLE -> stays IDLE.
REQ-035 SHALL cover: gen_valid[1]=1 while cur=0 -> no capture; gen_mask=0 with start -> stays IDLE.
REQ-036 SHALL cover: with GEN_SCHED_TIMEOUT_EN, TIMEOUT=4, generator 0 silent -> err=1 after 4 WAIT cycles, gen_en moves to the next mask bit, no out_valid pulse.
REQ-037 SHALL cover: rst pulled low during HOLD -> all outputs 0 immediately; no activity after release until a new start.
